// File: rtl/fib_stream_buffer.sv
// Consumer side of the Fibonacci generator: requests terms under credit control,
// buffers them in a small FIFO and replays them on a valid/ready stream.
module fib_stream_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  req_len,
  output logic              f_en,
  input  logic              f_valid,
  input  logic [DATA_W-1:0] f_out,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              wrap_err,
  output logic [LVL_W-1:0]  level
);

  // Stream handshake: an item transfers on every rising edge where m_valid and
  // m_ready are both high; m_valid/m_data never depend on m_ready.

  localparam int CW = LVL_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   accepted_q, accepted_d;
  logic [DATA_W-1:0]  prev_term_q, prev_term_d;
  logic               wrap_err_q, wrap_err_d;
  logic               done_q, done_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               credit_ok;
  logic [CW-1:0]      credit_need;
  logic               f_en_int;
  logic               capture;
  logic               wrap_now;
  logic               push;
  logic               pop;

  // Credit reserves a slot for the term already in flight; pops are ignored.
  always_comb begin
    credit_need = {1'b0, level_q} + CW'(f_valid) + CW'(1);
    credit_ok   = (credit_need <= CW'(DEPTH));
    f_en_int    = (state_q == RUN) && (issued_q < len_q) && !wrap_err_q && credit_ok;
    capture     = (state_q == RUN) && f_valid;
    wrap_now    = capture && (f_out < prev_term_q);
    push        = capture && !wrap_now;
    pop         = (level_q != '0) && m_ready;
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    accepted_d  = accepted_q;
    prev_term_d = prev_term_q;
    wrap_err_d  = wrap_err_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((req_len == '0) || wrap_err_q) begin
            done_d = 1'b1;
          end else begin
            len_d      = req_len;
            issued_d   = '0;
            accepted_d = '0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (f_en_int) begin
          issued_d = issued_q + LEN_W'(1);
        end
        if (push) begin
          accepted_d  = accepted_q + LEN_W'(1);
          prev_term_d = f_out;
        end
        // Leave RUN on the edge that captures the final term, so that term is
        // still at the FIFO head when DRAIN starts and can carry m_last.
        if (wrap_now) begin
          wrap_err_d = 1'b1;
          state_d    = DRAIN;
        end else if (accepted_d == len_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (level_q == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      prev_term_q <= '0;
      wrap_err_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      accepted_q  <= accepted_d;
      prev_term_q <= prev_term_d;
      wrap_err_q  <= wrap_err_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= f_out;
    end
  end

  push_when_full_a: assert property (@(posedge clock) disable iff (reset)
    !(push && (level_q == LVL_W'(DEPTH))));

  // A wrap ends the run in the same cycle, so the current head is the last item.
  always_comb begin
    m_valid  = (level_q != '0);
    m_data   = mem_q[rd_ptr_q];
    m_last   = m_valid && (level_q == LVL_W'(1)) && ((state_q == DRAIN) || wrap_now);
    busy     = (state_q != IDLE);
    done     = done_q || ((state_q == DRAIN) && (level_q == '0));
    wrap_err = wrap_err_q;
    level    = level_q;
    f_en     = f_en_int;
  end

endmodule

// File: tb/tb_fib_stream_buffer.sv
// Directed-plus-random bench for fib_stream_buffer with a behavioural Fibonacci
// generator and an expected-term queue built from plain 16-bit arithmetic.
module tb_fib_stream_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  req_len;
  logic        f_en;
  logic        f_valid;
  logic [15:0] f_out;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        wrap_err;
  logic [3:0]  level;

  int checks   = 0;
  int failures = 0;
  int fen_cnt  = 0;
  int done_cnt = 0;

  logic [15:0] fib16 [64];
  logic [15:0] exp_q [$];
  int          next_idx;
  logic [15:0] model_prev;
  logic        model_wrap;

  fib_stream_buffer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .req_len  (req_len),
    .f_en     (f_en),
    .f_valid  (f_valid),
    .f_out    (f_out),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .wrap_err (wrap_err),
    .level    (level)
  );

  always #5 clock = ~clock;

  // Generator: one term per f_en cycle, presented the following cycle.
  logic [15:0] gen_cur, gen_nxt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      f_valid <= 1'b0;
      f_out   <= 16'd0;
      gen_cur <= 16'd1;
      gen_nxt <= 16'd1;
    end else begin
      f_valid <= f_en;
      if (f_en) begin
        f_out   <= gen_cur;
        gen_cur <= gen_nxt;
        gen_nxt <= gen_cur + gen_nxt;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard and event counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (f_en) fen_cnt++;
      if (done) done_cnt++;
      if (m_valid && m_ready) begin
        check("pop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("m_data", m_data, exp_q.pop_front());
          check("m_last", m_last, exp_q.size() == 0);
        end
      end
    end
  end

  task automatic model_reset();
    next_idx   = 0;
    model_prev = 16'd0;
    model_wrap = 1'b0;
    exp_q.delete();
  endtask

  task automatic build_expected(input int len);
    logic [15:0] t;
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      t = fib16[next_idx];
      if (t < model_prev) begin
        model_wrap = 1'b1;
        break;
      end
      exp_q.push_back(t);
      model_prev = t;
      next_idx++;
    end
  endtask

  task automatic pulse_start(input int len);
    @(posedge clock); #1;
    start   = 1'b1;
    req_len = 8'(len);
    @(posedge clock); #1;
    start   = 1'b0;
  endtask

  // mode 0: m_ready held high; 1: random; 2: low for 30 cycles, then high.
  task automatic do_run(input int len, input int mode);
    logic saw;
    logic run_wraps;
    run_wraps = model_wrap;
    build_expected(len);
    run_wraps = model_wrap && !run_wraps;
    fen_cnt  = 0;
    done_cnt = 0;
    m_ready  = (mode == 0);
    pulse_start(len);
    saw = 1'b0;
    for (int c = 0; c < 2000 && !saw; c++) begin
      if (mode == 0)      m_ready = 1'b1;
      else if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      else                m_ready = (c >= 30);
      @(negedge clock);
      if (mode == 2 && c == 29) begin
        check("stall_level", level, 8);
        check("stall_fen", fen_cnt, 8);
        check("stall_busy", busy, 1);
      end
      if (done) saw = 1'b1;
      @(posedge clock); #1;
    end
    check("done_seen", saw, 1);
    repeat (3) @(posedge clock);
    #1;
    check("done_once", done_cnt, 1);
    check("all_popped", exp_q.size(), 0);
    check("end_level", level, 0);
    check("end_busy", busy, 0);
    check("wrap_err", wrap_err, model_wrap);
    if (!run_wraps) check("fen_cycles", fen_cnt, len);
  endtask

  task automatic do_null_start(input int len);
    fen_cnt  = 0;
    done_cnt = 0;
    pulse_start(len);
    @(negedge clock);
    check("null_done", done, 1);
    check("null_busy", busy, 0);
    repeat (4) @(posedge clock);
    #1;
    check("null_done_once", done_cnt, 1);
    check("null_fen", fen_cnt, 0);
    check("null_wrap_err", wrap_err, model_wrap);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_f_en", f_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap_err", wrap_err, 0);
    check("rst_level", level, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic reached;
    reset   = 1'b1;
    start   = 1'b0;
    req_len = 8'd0;
    m_ready = 1'b0;
    fib16[0] = 16'd1;
    fib16[1] = 16'd1;
    for (int i = 2; i < 64; i++) fib16[i] = fib16[i-1] + fib16[i-2];
    model_reset();
    repeat (2) @(posedge clock);
    apply_reset();

    do_run(5, 0);
    do_run(12, 2);
    do_run(3, 0);
    do_run($urandom_range(1, 4), 1);

    apply_reset();
    do_run(30, 0);
    do_null_start(4);

    apply_reset();
    m_ready = 1'b0;
    pulse_start(10);
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(negedge clock);
      if (level == 4'd4) reached = 1'b1;
    end
    check("midrun_level4", reached, 1);
    apply_reset();
    do_run(2, 1);
    do_null_start(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
